// File: rtl/spi_peripheral.sv
// SPI mode-0 peripheral: oversampled cs/sclk/mosi with one-byte transmit buffer
// and a held receive register with an overrun indication.
module spi_peripheral #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_cs,
    input  logic       i_sclk,
    input  logic       i_mosi,
    output logic       o_miso,
    output logic       o_miso_oe,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_valid,
    output logic       o_tx_ready,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    input  logic       i_rx_ready,
    output logic       o_busy,
    output logic       o_overrun
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_prev;
    logic [7:0]             r_tx_buf;
    logic                   r_tx_full;
    logic [7:0]             r_tx_shift;
    logic [7:0]             r_rx_shift;
    logic [2:0]             r_bit_cnt;
    logic [7:0]             r_rx_data;
    logic                   r_rx_valid;
    logic                   r_overrun;

    logic w_cs_s;
    logic w_sclk_s;
    logic w_mosi_s;
    logic w_start;
    logic w_stop;
    logic w_sample;
    logic w_drive;
    logic w_load;
    logic w_byte_done;

    // Synchronizers reset to the bus idle levels so a held-low cs after reset
    // still reads as a fresh high-to-low select.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_cs_sync   <= '1;
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_sclk_prev <= 1'b0;
        end else begin
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_cs};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
            r_sclk_prev <= w_sclk_s;
        end
    end

    assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
    assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_stop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_cs_s) begin
                    w_state_next = ST_ACTIVE;
                    w_start      = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (w_cs_s) begin
                    w_state_next = ST_IDLE;
                    w_stop       = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // A fall with the counter back at zero can only follow the 8th rise.
    assign w_sample    = (r_state == ST_ACTIVE) && !w_cs_s && w_sclk_s && !r_sclk_prev;
    assign w_drive     = (r_state == ST_ACTIVE) && !w_cs_s && !w_sclk_s && r_sclk_prev;
    assign w_load      = w_start || (w_drive && (r_bit_cnt == 3'd0));
    assign w_byte_done = w_sample && (r_bit_cnt == 3'd7);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_tx_buf   <= 8'h00;
            r_tx_full  <= 1'b0;
            r_tx_shift <= IDLE_BYTE;
        end else begin
            // A capture coinciding with a load into an empty buffer is kept for
            // the next load rather than bypassed into the shifter.
            if (w_load && r_tx_full) begin
                r_tx_full <= 1'b0;
            end else if (i_tx_valid && !r_tx_full) begin
                r_tx_buf  <= i_tx_data;
                r_tx_full <= 1'b1;
            end

            if (w_stop) begin
                r_tx_shift <= IDLE_BYTE;
            end else if (w_load) begin
                r_tx_shift <= r_tx_full ? r_tx_buf : IDLE_BYTE;
            end else if (w_drive) begin
                r_tx_shift <= {r_tx_shift[6:0], 1'b0};
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_rx_shift <= 8'h00;
            r_bit_cnt  <= 3'd0;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_stop) begin
                r_bit_cnt <= 3'd0;
            end else if (w_sample) begin
                r_rx_shift <= {r_rx_shift[6:0], w_mosi_s};
                r_bit_cnt  <= r_bit_cnt + 3'd1;
            end

            if (w_byte_done) begin
                r_rx_data  <= {r_rx_shift[6:0], w_mosi_s};
                r_rx_valid <= 1'b1;
                r_overrun  <= r_rx_valid && !i_rx_ready;
            end else if (r_rx_valid && i_rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign o_miso     = r_tx_shift[7];
    assign o_miso_oe  = (r_state == ST_ACTIVE);
    assign o_busy     = (r_state == ST_ACTIVE);
    assign o_tx_ready = !r_tx_full;
    assign o_rx_data  = r_rx_data;
    assign o_rx_valid = r_rx_valid;
    assign o_overrun  = r_overrun;

endmodule

// File: tb/tb_spi_peripheral.sv
// Bench for spi_peripheral: acts as SPI controller, predicts miso/rx bytes per
// transaction and checks bus-state and handshake behaviour every cycle.
module tb_spi_peripheral;

    localparam int         SYNC   = 2;
    localparam logic [7:0] IDLE_B = 8'hFF;
    localparam int         HALF   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cs = 1'b1;
    logic       sclk = 1'b0;
    logic       mosi = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       rx_ready = 1'b0;
    logic       o_miso, o_miso_oe, o_tx_ready, o_rx_valid, o_busy, o_overrun;
    logic [7:0] o_rx_data;

    int         checks = 0;
    int         failures = 0;
    int         overruns = 0;
    int         lowc = 0;
    int         highc = 0;
    bit         rx_hold = 1'b0;
    logic [7:0] exp_rx[$];

    spi_peripheral #(.SYNC_STAGES(SYNC), .IDLE_BYTE(IDLE_B)) dut (
        .i_clock   (clk),
        .i_reset   (rst),
        .i_cs      (cs),
        .i_sclk    (sclk),
        .i_mosi    (mosi),
        .o_miso    (o_miso),
        .o_miso_oe (o_miso_oe),
        .i_tx_data (tx_data),
        .i_tx_valid(tx_valid),
        .o_tx_ready(o_tx_ready),
        .o_rx_data (o_rx_data),
        .o_rx_valid(o_rx_valid),
        .i_rx_ready(rx_ready),
        .o_busy    (o_busy),
        .o_overrun (o_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Per-cycle compare: bus state follows the settled cs pin, and every
    // accepted byte matches the next byte the controller sent.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            lowc  = 0;
            highc = 0;
        end else if (cs) begin
            highc++;
            lowc = 0;
        end else begin
            lowc++;
            highc = 0;
        end
        if (lowc > SYNC + 2) begin
            chk("busy_selected", o_busy, 1);
            chk("oe_selected", o_miso_oe, 1);
        end
        if (highc > SYNC + 2) begin
            chk("busy_deselected", o_busy, 0);
            chk("oe_deselected", o_miso_oe, 0);
            chk("miso_idle", o_miso, IDLE_B[7]);
        end
        if (o_overrun) overruns++;
        rx_ready = rx_hold ? 1'b0 : 1'($urandom_range(0, 1));
        if (o_rx_valid && rx_ready) begin
            if (exp_rx.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rx_unexpected actual=%0h required=none", o_rx_data);
            end else begin
                chk("rx_data", o_rx_data, exp_rx.pop_front());
            end
        end
    end

    task automatic tx_preload(input logic [7:0] b);
        chk("tx_ready_empty", o_tx_ready, 1);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("tx_ready_full", o_tx_ready, 0);
    endtask

    task automatic frame_start();
        cs = 1'b0;
        repeat (8) @(negedge clk);
        chk("tx_ready_after_load", o_tx_ready, 1);
    endtask

    task automatic frame_end();
        cs = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // Mode 0: mosi set while sclk low, miso sampled at the rise. Optionally
    // buffers push_b during the first high phase for the next load.
    task automatic spi_xfer(input logic [7:0] mo, input int nbits, input bit push,
                            input logic [7:0] push_b, output logic [7:0] mi);
        bit pre;
        bit seen;
        mi = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            mosi = mo[i];
            repeat (HALF) @(negedge clk);
            mi[i] = o_miso;
            pre   = o_rx_valid;
            seen  = 1'b0;
            sclk  = 1'b1;
            for (int k = 1; k <= HALF; k++) begin
                if (k == 1 && push && i == 7) begin
                    chk("tx_ready_mid", o_tx_ready, 1);
                    tx_data  = push_b;
                    tx_valid = 1'b1;
                end
                @(negedge clk);
                if (k == 1 && tx_valid) begin
                    tx_valid = 1'b0;
                    chk("tx_ready_mid_full", o_tx_ready, 0);
                end
                if (k <= SYNC + 2 && o_rx_valid) seen = 1'b1;
            end
            if (i == 0 && !pre) chk("rx_latency", seen, 1);
            sclk = 1'b0;
        end
        repeat (HALF) @(negedge clk);
    endtask

    task automatic drain();
        for (int n = 0; n < 300 && exp_rx.size() != 0; n++) @(negedge clk);
        if (exp_rx.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL rx_drain actual=%0d pending required=0", exp_rx.size());
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_miso"}, o_miso, 1);
        chk({tag, "_oe"}, o_miso_oe, 0);
        chk({tag, "_tx_ready"}, o_tx_ready, 1);
        chk({tag, "_rx_data"}, o_rx_data, 8'h00);
        chk({tag, "_rx_valid"}, o_rx_valid, 0);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_overrun"}, o_overrun, 0);
    endtask

    initial begin
        logic [7:0] mi;
        logic [7:0] mo;
        logic [7:0] pb;
        logic [7:0] exp_m;
        int         ov0;
        int         nb;
        bit         pushn;

        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Buffered A5 out while 3C comes in.
        tx_preload(8'hA5);
        frame_start();
        exp_rx.push_back(8'h3C);
        spi_xfer(8'h3C, 8, 1'b0, 8'h00, mi);
        chk("a5_miso", mi, 8'hA5);
        frame_end();
        drain();

        // Empty buffer: idle byte twice.
        frame_start();
        exp_rx.push_back(8'h01);
        spi_xfer(8'h01, 8, 1'b0, 8'h00, mi);
        chk("idle_miso_0", mi, 8'hFF);
        exp_rx.push_back(8'h02);
        spi_xfer(8'h02, 8, 1'b0, 8'h00, mi);
        chk("idle_miso_1", mi, 8'hFF);
        frame_end();
        drain();

        // Consumer stalled across two bytes.
        rx_hold = 1'b1;
        @(negedge clk);
        ov0 = overruns;
        frame_start();
        spi_xfer(8'h11, 8, 1'b0, 8'h00, mi);
        spi_xfer(8'h22, 8, 1'b0, 8'h00, mi);
        frame_end();
        chk("ovr_rx_data", o_rx_data, 8'h22);
        chk("ovr_rx_valid", o_rx_valid, 1);
        chk("ovr_pulses", overruns - ov0, 1);
        exp_rx.push_back(8'h22);
        rx_hold = 1'b0;
        drain();

        // Deselect after 5 rises; the byte buffered meanwhile must survive.
        frame_start();
        spi_xfer(8'hA8, 5, 1'b1, 8'h5A, mi);
        frame_end();
        chk("abort_busy", o_busy, 0);
        chk("abort_oe", o_miso_oe, 0);
        chk("abort_rx_valid", o_rx_valid, 0);
        chk("abort_tx_ready", o_tx_ready, 0);
        frame_start();
        exp_rx.push_back(8'h7E);
        spi_xfer(8'h7E, 8, 1'b0, 8'h00, mi);
        chk("abort_next_miso", mi, 8'h5A);
        frame_end();
        drain();

        // Reset pulse after 3 bits, with a byte buffered.
        frame_start();
        spi_xfer(8'hE0, 3, 1'b1, 8'h99, mi);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        cs = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        frame_start();
        exp_rx.push_back(8'hC3);
        spi_xfer(8'hC3, 8, 1'b0, 8'h00, mi);
        chk("post_reset_miso", mi, 8'hFF);
        frame_end();
        drain();

        // Randomized frames of 1-3 bytes with random transmit buffering.
        for (int f = 0; f < 10; f++) begin
            nb = int'($urandom_range(1, 3));
            pb = 8'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                tx_preload(pb);
                exp_m = pb;
            end else begin
                exp_m = IDLE_B;
            end
            frame_start();
            for (int k = 0; k < nb; k++) begin
                mo    = 8'($urandom);
                pb    = 8'($urandom);
                pushn = (k < nb - 1) && ($urandom_range(0, 1) == 1);
                exp_rx.push_back(mo);
                spi_xfer(mo, 8, pushn, pb, mi);
                chk("rand_miso", mi, exp_m);
                exp_m = pushn ? pb : IDLE_B;
            end
            frame_end();
            drain();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_peripheral.md
SPI_PERIPHERAL -- requirements
Module: spi_peripheral

Interface
REQ-001 Parameter SYNC_STAGES, default 2: flop depth of the cs/sclk/mosi input synchronizers (minimum 2).
REQ-002 Parameter IDLE_BYTE, default 8'hFF: byte shifted out when no transmit byte is buffered.
REQ-003 Port clock  input  1  single system clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port cs  input  1  SPI chip select from the controller, active-low, asynchronous to clock.
REQ-006 Port sclk  input  1  SPI serial clock, mode 0 (CPOL=0, CPHA=0), asynchronous to clock.
REQ-007 Port mosi  input  1  serial data from the controller, MSB first.
REQ-008 Port miso  output  1  serial data to the controller, MSB first.
REQ-009 Port miso_oe  output  1  miso output enable; high only while selected.
REQ-010 Port tx_data  input  8  byte to transmit.
REQ-011 Port tx_valid  input  1  tx_data valid.
REQ-012 Port tx_ready  output  1  one-entry transmit buffer empty.
REQ-013 Port rx_data  output  8  last received byte.
REQ-014 Port rx_valid  output  1  rx_data valid, held until accepted.
REQ-015 Port rx_ready  input  1  consumer accepts rx_data.
REQ-016 Port busy  output  1  high while in state ACTIVE.
REQ-017 Port overrun  output  1  one-cycle pulse when an unaccepted received byte is overwritten.

Function
REQ-018 cs, sclk and mosi SHALL each pass through SYNC_STAGES flops; sclk rise/fall SHALL be detected from the synchronized signal.
REQ-019 Correct operation requires sclk high and low phases each >= 4 clock periods; behaviour outside this limit is unspecified.
REQ-020 FSM states: IDLE, ACTIVE. IDLE->ACTIVE on synchronized cs low; ACTIVE->IDLE on synchronized cs high; no other transitions.
REQ-021 On IDLE->ACTIVE and after each 8th sampled bit, the shifter SHALL load the buffered tx byte (freeing the buffer, tx_ready=1 next cycle), or IDLE_BYTE if the buffer is empty.
REQ-022 miso SHALL equal shifter bit 7; the shifter SHALL load on the IDLE->ACTIVE transition and then shift left on each synchronized sclk fall, except that the fall following the 8th rise loads the next byte (REQ-021) instead of shifting.
REQ-023 On each synchronized sclk rise in ACTIVE, mosi SHALL be shifted into the receive shifter at bit 0 and the 3-bit bit counter incremented, wrapping 7->0.
REQ-024 On the 8th rise the completed byte SHALL be written to rx_data with rx_valid=1 on the next clock, no more than SYNC_STAGES+2 clock cycles after the sclk pin edge.
REQ-025 rx_valid SHALL clear on the cycle after rx_valid && rx_ready; if a new byte completes while rx_valid=1 and rx_ready=0, rx_data SHALL be overwritten, rx_valid SHALL remain 1 and overrun SHALL pulse for one cycle.
REQ-026 If a byte completes in the same cycle that rx_valid && rx_ready, the new byte SHALL be captured, rx_valid SHALL remain 1 and overrun SHALL not pulse.
REQ-027 tx_valid && tx_ready SHALL capture tx_data into the buffer and drop tx_ready next cycle; a load in the same cycle as a capture into an empty buffer SHALL use IDLE_BYTE (no bypass), and the new byte SHALL remain buffered.
REQ-028 cs deassertion mid-byte SHALL discard the partial receive byte (no rx_valid), clear the bit counter, and discard the byte already in the transmit shifter; the tx buffer contents SHALL be kept.
REQ-029 miso_oe SHALL equal 1 in ACTIVE and 0 in IDLE; busy SHALL equal 1 in ACTIVE.
REQ-030 sclk edges while synchronized cs is high SHALL be ignored.

Reset
REQ-031 reset SHALL act immediately, regardless of clock, forcing IDLE with bit counter=0, synchronizers=idle levels (cs=1, sclk=0, mosi=0), tx buffer empty, and shifter=IDLE_BYTE.
REQ-032 Output reset values: miso=1, miso_oe=0, tx_ready=1, rx_data=8'h00, rx_valid=0, busy=0, overrun=0.
REQ-033 reset asserted mid-transfer SHALL abort the transfer; after release, the block SHALL stay in IDLE until cs is seen high then low (REQ-020 via the idle-level synchronizer).

Verification
REQ-034 Buffer tx 8'hA5, cs low, controller sends 8'h3C with 8 clock periods per sclk cycle -> miso bits 1,0,1,0,0,1,0,1; rx_data=8'h3C, rx_valid=1 within SYNC_STAGES+2 clocks of 8th rise.
REQ-035 Empty tx buffer, 2-byte transfer of 8'h01, 8'h02 -> miso returns 8'hFF twice; two rx_valid events.
REQ-036 rx_ready held 0 across two received bytes 8'h11, 8'h22 -> rx_data=8'h22, rx_valid=1, exactly one overrun pulse.
REQ-037 cs raised after 5 sclk rises -> no rx_valid, busy=0, miso_oe=0; next full byte 8'h7E received correctly.
REQ-038 reset pulsed after 3 bits -> all outputs at REQ-032 values immediately; subsequent cs-low frame transfers 8'hC3 correctly.
